// File: rtl/ram_lsu.sv
`default_nettype none
// ============================================================================
// Module      : ram_lsu
// Description : Load/store unit driving a 32-bit single-port data RAM.
//               Accepts byte/half/word loads and stores over a valid/ready
//               handshake. Sub-word stores are read-modify-write. Loads
//               return sign- or zero-extended lane data.
//               Optional macro LSU_MISALIGN_TRAP_EN: when defined, misaligned
//               or reserved-size requests respond with rsp_err and leave the
//               RAM untouched. When undefined, such requests are force-aligned
//               and size 2'b11 behaves as a word access.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_lsu #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              ram_readWrite,
  output logic [ADDR_W-1:0] ram_address,
  output logic [31:0]       ram_dataIN,
  input  logic [31:0]       ram_dataOUT
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t            state_q, state_d;

  // Latched request fields (size/offset are post-alignment values)
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [1:0]        off_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       rbuf_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [31:0]       ram_din_q;

  logic              w_accept;
  logic              w_req_err;
  logic [1:0]        w_req_size;
  logic [1:0]        w_req_off;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load_ext;
  logic [31:0]       w_merged;

  assign w_accept = req_valid && (state_q == S_IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  // Classify the incoming request; misaligned or reserved sizes take the error path
  always_comb begin
    w_req_size = req_size;
    w_req_off  = req_addr[1:0];
    w_req_err  = 1'b0;
    unique case (req_size)
      SZ_BYTE: w_req_err = 1'b0;
      SZ_HALF: w_req_err = req_addr[0];
      SZ_WORD: w_req_err = (req_addr[1:0] != 2'b00);
      default: w_req_err = 1'b1;
    endcase
  end
`else
  // Force-align the incoming request; reserved size behaves as a word access
  always_comb begin
    w_req_err  = 1'b0;
    w_req_size = SZ_WORD;
    w_req_off  = 2'b00;
    unique case (req_size)
      SZ_BYTE: begin
        w_req_size = SZ_BYTE;
        w_req_off  = req_addr[1:0];
      end
      SZ_HALF: begin
        w_req_size = SZ_HALF;
        w_req_off  = {req_addr[1], 1'b0};
      end
      default: begin
        w_req_size = SZ_WORD;
        w_req_off  = 2'b00;
      end
    endcase
  end
`endif

  // Extract the addressed lane from the captured word and extend it
  always_comb begin
    w_byte     = rbuf_q[{off_q, 3'b000} +: 8];
    w_half     = off_q[1] ? rbuf_q[31:16] : rbuf_q[15:0];
    w_load_ext = rbuf_q;
    unique case (size_q)
      SZ_BYTE: w_load_ext = {{24{~uns_q & w_byte[7]}}, w_byte};
      SZ_HALF: w_load_ext = {{16{~uns_q & w_half[15]}}, w_half};
      default: w_load_ext = rbuf_q;
    endcase
  end

  // Merge store data into the word read back from RAM
  always_comb begin
    w_merged = ram_dataOUT;
    unique case (size_q)
      SZ_BYTE: w_merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      SZ_HALF: begin
        if (off_q[1]) begin
          w_merged[31:16] = wdata_q[15:0];
        end else begin
          w_merged[15:0] = wdata_q[15:0];
        end
      end
      default: w_merged = wdata_q;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_err       = 1'b0;
    rsp_rdata     = 32'h0;
    ram_readWrite = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_req_err) begin
            state_d = S_RESP;
          end else if (req_we && (w_req_size == SZ_WORD)) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD:  state_d = S_CAP;
      S_CAP: state_d = we_q ? S_WR : S_RESP;
      S_WR: begin
        ram_readWrite = 1'b1;
        state_d       = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        if (!we_q && !err_q) begin
          rsp_rdata = w_load_ext;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, RAM address/data registers and read capture buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      size_q     <= SZ_BYTE;
      uns_q      <= 1'b0;
      off_q      <= 2'b00;
      wdata_q    <= 32'h0;
      err_q      <= 1'b0;
      rbuf_q     <= 32'h0;
      ram_addr_q <= '0;
      ram_din_q  <= 32'h0;
    end else begin
      if (w_accept) begin
        we_q    <= req_we;
        size_q  <= w_req_size;
        uns_q   <= req_unsigned;
        off_q   <= w_req_off;
        wdata_q <= req_wdata;
        err_q   <= w_req_err;
        // Erroring requests never touch the RAM, so leave its address alone
        if (!w_req_err) begin
          ram_addr_q <= req_addr[ADDR_W+1:2];
        end
        if (req_we && (w_req_size == SZ_WORD) && !w_req_err) begin
          ram_din_q <= req_wdata;
        end
      end
      if (state_q == S_CAP) begin
        rbuf_q <= ram_dataOUT;
        if (we_q) begin
          ram_din_q <= w_merged;
        end
      end
    end
  end

  assign ram_address = ram_addr_q;
  assign ram_dataIN  = ram_din_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_lsu
// Description : Scoreboard bench for ram_lsu with a behavioural 32-word RAM.
//               Honours LSU_MISALIGN_TRAP_EN for misaligned expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_lsu;

  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              ram_readWrite;
  logic [ADDR_W-1:0] ram_address;
  logic [31:0]       ram_dataIN;
  logic [31:0]       ram_dataOUT;

  logic [31:0]       mem [0:31];

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int write_cnt = 0;
  int rsp_cnt   = 0;
  int acc_cnt   = 0;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_q[$];

  ram_lsu #(.ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .ram_readWrite (ram_readWrite),
    .ram_address   (ram_address),
    .ram_dataIN    (ram_dataIN),
    .ram_dataOUT   (ram_dataOUT)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: registered read, write at the rising edge
  always @(posedge clk) begin
    ram_dataOUT <= mem[ram_address];
    if (ram_readWrite) mem[ram_address] = ram_dataIN;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_readWrite) write_cnt <= write_cnt + 1;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // Monitor: pops one expectation per response pulse
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      rsp_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual=1 required=0");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.name, "_rdata"}, rsp_rdata, e.rdata);
        chk({e.name, "_err"}, {31'h0, rsp_err}, {31'h0, e.err});
        chk({e.name, "_lat"}, cyc - e.acc, e.lat);
      end
    end
  end

  task automatic issue(string name, logic we, logic [1:0] size, logic uns,
                       logic [6:0] addr, logic [31:0] wd,
                       logic [31:0] er, logic ee, int el);
    int   guard;
    exp_t e;
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    guard        = 0;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_accept_timeout actual=0 required=1", name);
      req_valid = 1'b0;
      return;
    end
    e.name  = name;
    e.rdata = er;
    e.err   = ee;
    e.lat   = el;
    e.acc   = cyc;
    sb_q.push_back(e);
    acc_cnt++;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
    chk({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_rsp_err"}, {31'h0, rsp_err}, 32'h0);
    chk({tag, "_ram_rw"}, {31'h0, ram_readWrite}, 32'h0);
    chk({tag, "_ram_addr"}, {27'h0, ram_address}, 32'h0);
    chk({tag, "_ram_din"}, ram_dataIN, 32'h0);
  endtask

  initial begin
    int wr_before;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[1]  = 32'hCAFEF00D;
    mem[4]  = 32'h00000055;
    mem[5]  = 32'h01234567;
    mem[31] = 32'h11223344;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;

    // Reset in the middle of a word-store write cycle
    issue("rst_st", 1'b1, 2'b10, 1'b0, 7'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    chk("rst_wr_active", {31'h0, ram_readWrite}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midwr");
    sb_q.delete();
    acc_cnt--;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mem4", mem[4], 32'h00000055);
    rst_n = 1'b1;
    mem[4] = 32'h80000012;

    // Word store then word load
    issue("st_w", 1'b1, 2'b10, 1'b0, 7'h74, 32'd24, 32'h0, 1'b0, 2);
    drain();
    chk("mem29", mem[29], 32'd24);
    issue("ld_w", 1'b0, 2'b10, 1'b0, 7'h74, 32'h0, 32'd24, 1'b0, 3);
    drain();

    // Byte read-modify-write and byte loads
    issue("st_b", 1'b1, 2'b00, 1'b0, 7'h7D, 32'h000000AB, 32'h0, 1'b0, 4);
    drain();
    chk("mem31", mem[31], 32'h1122AB44);
    issue("ld_bs", 1'b0, 2'b00, 1'b0, 7'h7D, 32'h0, 32'hFFFFFFAB, 1'b0, 3);
    issue("ld_bu", 1'b0, 2'b00, 1'b1, 7'h7D, 32'h0, 32'h000000AB, 1'b0, 3);
    drain();

    // Half loads
    issue("ld_hs", 1'b0, 2'b01, 1'b0, 7'h12, 32'h0, 32'hFFFF8000, 1'b0, 3);
    issue("ld_hu", 1'b0, 2'b01, 1'b1, 7'h12, 32'h0, 32'h00008000, 1'b0, 3);
    issue("ld_hl", 1'b0, 2'b01, 1'b0, 7'h10, 32'h0, 32'h00000012, 1'b0, 3);
    drain();

    // Upper-half store and read back
    issue("st_h", 1'b1, 2'b01, 1'b0, 7'h16, 32'h0000BEEF, 32'h0, 1'b0, 4);
    drain();
    chk("mem5", mem[5], 32'hBEEF4567);
    issue("ld_h5", 1'b0, 2'b01, 1'b1, 7'h16, 32'h0, 32'h0000BEEF, 1'b0, 3);
    drain();

    // Misaligned and reserved-size requests
    wr_before = write_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
    issue("mis_w", 1'b0, 2'b10, 1'b0, 7'h05, 32'h0, 32'h0, 1'b1, 1);
    issue("rsv_sz", 1'b0, 2'b11, 1'b0, 7'h7C, 32'h0, 32'h0, 1'b1, 1);
    issue("mis_sth", 1'b1, 2'b01, 1'b0, 7'h13, 32'h00001234, 32'h0, 1'b1, 1);
    drain();
    chk("mis_no_write", write_cnt - wr_before, 32'd0);
    chk("mis_mem4", mem[4], 32'h80000012);
`else
    issue("mis_w", 1'b0, 2'b10, 1'b0, 7'h05, 32'h0, 32'hCAFEF00D, 1'b0, 3);
    issue("rsv_sz", 1'b0, 2'b11, 1'b0, 7'h7C, 32'h0, 32'h1122AB44, 1'b0, 3);
    issue("mis_sth", 1'b1, 2'b01, 1'b0, 7'h13, 32'h00001234, 32'h0, 1'b0, 4);
    drain();
    chk("mis_one_write", write_cnt - wr_before, 32'd1);
    chk("mis_mem4", mem[4], 32'h12340012);
`endif

    // Handshake: second request held valid while the first is in flight
    issue("hs_a", 1'b0, 2'b10, 1'b0, 7'h74, 32'h0, 32'd24, 1'b0, 3);
    chk("hs_busy_ready", {31'h0, req_ready}, 32'h0);
    issue("hs_b", 1'b0, 2'b00, 1'b1, 7'h7D, 32'h0, 32'h000000AB, 1'b0, 3);
    drain();
    repeat (3) @(negedge clk);

    chk("rsp_count", rsp_cnt, acc_cnt);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("write_total", write_cnt, 32'd3);
`else
    chk("write_total", write_cnt, 32'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
